// File: rtl/tsp_result_display.sv
// Result-stream consumer for the TSP solver: buffers one tour, converts its cost
// to BCD with a serial double-dabble, and drives six 7-segment digits plus LEDs.
module tsp_result_display #(
  parameter int MAX_CITIES = 16,
  parameter int CITY_W     = 4,
  parameter int COST_W     = 20,
  parameter int SCROLL_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [CITY_W-1:0] res_city,
  input  logic              res_last,
  input  logic [COST_W-1:0] res_cost,
  input  logic [1:0]        SW,
  output logic [3:0]        LEDR,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5
);

  localparam int CNT_W = $clog2(MAX_CITIES + 1);
  localparam int POS_W = (MAX_CITIES > 1) ? $clog2(MAX_CITIES) : 1;
  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BIT_W = $clog2(COST_W + 1);
  localparam int unsigned NDIG_RAW = (COST_W * 301) / 1000 + 1;
  localparam int unsigned NDIG     = (NDIG_RAW < 6) ? 6 : NDIG_RAW;
  localparam int BCD_W = 4 * NDIG;

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CITIES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(COST_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_SHOW} state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [CITY_W-1:0]  tour_q [MAX_CITIES];
  logic [CITY_W-1:0]  tour_d [MAX_CITIES];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [COST_W-1:0]  cost_q, cost_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               ovf_q, ovf_d;
  logic               sat_q, sat_d;
  logic [1:0]         sw_q, sw_d;
  logic [3:0]         ledr_q, ledr_d;
  logic [6:0]         hex_q [6];
  logic [6:0]         hex_d [6];

  logic               fire;
  logic [BCD_W-1:0]   bcd_adj, bcd_shift;
  logic               sat_hit;
  logic               lead;
  logic [3:0]         dig;
  logic [7:0]         pos_num, entry8;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    tour_d  = tour_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    div_d   = div_q;
    cost_d  = cost_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    sw_d    = SW;
    fire    = res_valid && ready_q;

    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NDIG; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    bcd_shift = BCD_W'({bcd_adj, cost_q[COST_W-1]});
    sat_hit = 1'b0;
    for (int unsigned i = 6; i < NDIG; i++)
      if (bcd_shift[4*i +: 4] != 4'd0) sat_hit = 1'b1;

    case (state_q)
      S_LOAD: begin
        if (fire) begin
          if (cnt_q < MAX_C) begin
            tour_d[cnt_q[POS_W-1:0]] = res_city;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (res_last) begin
            cost_d  = res_cost;
            bcd_d   = '0;
            bit_d   = '0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        cost_d = {cost_q[COST_W-2:0], 1'b0};
        bcd_d  = bcd_shift;
        bit_d  = bit_q + BIT_W'(1);
        if (bit_q == BIT_LAST) begin
          state_d = S_SHOW;
          pos_d   = '0;
          div_d   = '0;
          if (sat_hit) begin
            bcd_d = '0;
            for (int unsigned i = 0; i < 6; i++) bcd_d[4*i +: 4] = 4'd9;
            sat_d = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and SHOW share the tour-start path; SHOW additionally scrolls
        if (fire) begin
          tour_d[0] = res_city;
          cnt_d     = CNT_W'(1);
          ovf_d     = 1'b0;
          sat_d     = 1'b0;
          if (res_last) begin
            cost_d  = res_cost;
            bcd_d   = '0;
            bit_d   = '0;
            state_d = S_CONV;
          end else begin
            state_d = S_LOAD;
          end
        end else if (state_q == S_SHOW && !sw_q[1]) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (CNT_W'(pos_q) + CNT_W'(1) >= cnt_q) pos_d = '0;
            else                                     pos_d = pos_q + POS_W'(1);
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
    endcase

    ready_d = (state_d != S_CONV);
  end

  always_comb begin
    for (int unsigned i = 0; i < 6; i++) hex_d[i] = 7'h7F;
    ledr_d  = {sat_q, ovf_q, state_q == S_SHOW, state_q == S_LOAD || state_q == S_CONV};
    lead    = 1'b1;
    dig     = '0;
    pos_num = 8'(pos_q) + 8'd1;
    entry8  = 8'(tour_q[pos_q]);
    case (state_q)
      S_IDLE: ;
      S_LOAD, S_CONV: for (int unsigned i = 0; i < 6; i++) hex_d[i] = 7'h3F;
      default: begin
        if (sw_q[0]) begin
          hex_d[5] = seg7(pos_num[7:4]);
          hex_d[4] = seg7(pos_num[3:0]);
          hex_d[1] = seg7(entry8[7:4]);
          hex_d[0] = seg7(entry8[3:0]);
        end else begin
          for (int unsigned k = 0; k < 6; k++) begin
            dig = bcd_q[4*(5-k) +: 4];
            if (k == 5 || dig != 4'd0 || !lead) begin
              lead = 1'b0;
              hex_d[5-k] = seg7(dig);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      tour_q  <= '{default: '0};
      cnt_q   <= '0;
      pos_q   <= '0;
      div_q   <= '0;
      cost_q  <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
      sw_q    <= '0;
      ledr_q  <= '0;
      hex_q   <= '{default: 7'h7F};
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      tour_q  <= tour_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      cost_q  <= cost_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
      sw_q    <= sw_d;
      ledr_q  <= ledr_d;
      hex_q   <= hex_d;
    end
  end

  assign res_ready = ready_q;
  assign LEDR      = ledr_q;
  assign HEX0      = hex_q[0];
  assign HEX1      = hex_q[1];
  assign HEX2      = hex_q[2];
  assign HEX3      = hex_q[3];
  assign HEX4      = hex_q[4];
  assign HEX5      = hex_q[5];

endmodule
